// File: rtl/long_divider.sv
`default_nettype none
// ============================================================================
// Module   : long_divider
// Purpose  : Iterative restoring divider, 2*WIDTH-bit dividend by WIDTH-bit
//            divisor, signed or unsigned, one quotient bit per clock.
// Revision : 1.0  initial release
// ============================================================================
module long_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_hi_i,
  input  logic [WIDTH-1:0] dividend_lo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             overflow_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;
  logic               div_zero_q;
  logic               overflow_q;

  logic               signed_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   dvs_q;

  logic [WIDTH-1:0]   prem_q;   // partial remainder
  logic [WIDTH-1:0]   qlo_q;    // dividend low bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   dmag_q;
  logic               qsign_q;
  logic               rsign_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [2*WIDTH-1:0] w_dvd_raw;
  logic [2*WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0]   w_dvd_mag_hi;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_dmag_ext;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic               w_q_ovf;

  always_comb begin
    w_dvd_raw    = {hi_q, lo_q};
    w_dvd_neg    = signed_q & hi_q[WIDTH-1];
    w_dvs_neg    = signed_q & dvs_q[WIDTH-1];
    w_dvd_mag    = w_dvd_neg ? -w_dvd_raw : w_dvd_raw;
    w_dvd_mag_hi = w_dvd_mag[2*WIDTH-1:WIDTH];
    w_dvs_mag    = w_dvs_neg ? -dvs_q : dvs_q;
    // Extra top bit keeps the bit shifted out of the partial remainder.
    w_shift      = {prem_q, qlo_q[WIDTH-1]};
    w_dmag_ext   = {1'b0, dmag_q};
    w_ge         = (w_shift >= w_dmag_ext);
    w_diff       = w_shift - w_dmag_ext;
    // Negative results may reach -2^(WIDTH-1); positive ones stop one short.
    w_q_ovf      = qsign_q ? (qlo_q[WIDTH-1] & (|qlo_q[WIDTH-2:0])) : qlo_q[WIDTH-1];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
      signed_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      qlo_q      <= '0;
      dmag_q     <= '0;
      qsign_q    <= 1'b0;
      rsign_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            signed_q   <= signed_i;
            hi_q       <= dividend_hi_i;
            lo_q       <= dividend_lo_i;
            dvs_q      <= divisor_i;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_PREP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_PREP: begin
          qsign_q <= w_dvd_neg ^ w_dvs_neg;
          rsign_q <= w_dvd_neg;
          if (dvs_q == '0) begin
            div_zero_q <= 1'b1;
            quot_q     <= '1;
            rem_q      <= lo_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else if (w_dvd_mag_hi >= w_dvs_mag) begin
            overflow_q <= 1'b1;
            quot_q     <= '1;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            prem_q  <= w_dvd_mag_hi;
            qlo_q   <= w_dvd_mag[WIDTH-1:0];
            dmag_q  <= w_dvs_mag;
            cnt_q   <= '0;
            state_q <= S_DIV;
          end
        end

        S_DIV: begin
          prem_q <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          qlo_q  <= {qlo_q[WIDTH-2:0], w_ge};
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          if (signed_q && w_q_ovf) begin
            overflow_q <= 1'b1;
            quot_q     <= '1;
            rem_q      <= '0;
          end else if (signed_q) begin
            quot_q <= qsign_q ? -qlo_q : qlo_q;
            rem_q  <= rsign_q ? -prem_q : prem_q;
          end else begin
            quot_q <= qlo_q;
            rem_q  <= prem_q;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = div_zero_q;
  assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_long_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_long_divider
// Purpose  : Directed self-checking bench for long_divider.
// Revision : 1.0  initial release
// ============================================================================
module tb_long_divider;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_hi_i;
  logic [WIDTH-1:0] dividend_lo_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;
  logic             overflow_o;

  int total = 0;
  int bad   = 0;

  long_divider #(.WIDTH(WIDTH)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .signed_i      (signed_i),
    .dividend_hi_i (dividend_hi_i),
    .dividend_lo_i (dividend_lo_i),
    .divisor_i     (divisor_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_zero_o    (div_zero_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive operands and Start at a falling edge; the next rising edge is cycle 0.
  task automatic start_div(input logic sg, input logic [31:0] hi, input logic [31:0] lo,
                           input logic [31:0] dv);
    @(negedge clk_i);
    signed_i      = sg;
    dividend_hi_i = hi;
    dividend_lo_i = lo;
    divisor_i     = dv;
    start_i       = 1'b1;
  endtask

  // Returns the cycle Done appears in (0 on timeout) and how many earlier cycles had Busy.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) begin
        lat = c;
        return;
      end
      if (busy_o) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    start_i = 1'b0;
    signed_i = 1'b0;
    dividend_hi_i = '0;
    dividend_lo_i = '0;
    divisor_i = '0;
    repeat (3) @(negedge clk_i);
    total++; if ({busy_o, done_o, div_zero_o, overflow_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {busy_o, done_o, div_zero_o, overflow_o});
    end
    total++; if (quotient_o !== 32'd0) begin
      bad++; $display("FAIL reset_quot got=%h want=0", quotient_o);
    end
    total++; if (remainder_o !== 32'd0) begin
      bad++; $display("FAIL reset_rem got=%h want=0", remainder_o);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_unsigned;
    int lat, bc;
    start_div(1'b0, 32'd0, 32'd100, 32'd7);
    wait_done(lat, bc);
    total++; if (lat !== 35) begin bad++; $display("FAIL u_latency got=%0d want=35", lat); end
    total++; if (bc !== 34) begin bad++; $display("FAIL u_busy_cycles got=%0d want=34", bc); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL u_busy_at_done got=%b want=0", busy_o); end
    total++; if (quotient_o !== 32'd14) begin bad++; $display("FAIL u_quot got=%h want=e", quotient_o); end
    total++; if (remainder_o !== 32'd2) begin bad++; $display("FAIL u_rem got=%h want=2", remainder_o); end
    total++; if ({div_zero_o, overflow_o} !== 2'b00) begin
      bad++; $display("FAIL u_flags got=%b want=00", {div_zero_o, overflow_o});
    end
    @(negedge clk_i);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL u_done_pulse got=%b want=0", done_o); end
    total++; if (quotient_o !== 32'd14) begin bad++; $display("FAIL u_quot_held got=%h want=e", quotient_o); end
  endtask

  task automatic test_unsigned_wide;
    int lat, bc;
    start_div(1'b0, 32'h1, 32'h0, 32'd2);
    wait_done(lat, bc);
    total++; if (quotient_o !== 32'h8000_0000) begin
      bad++; $display("FAIL uw_quot got=%h want=80000000", quotient_o);
    end
    total++; if ({remainder_o, overflow_o} !== {32'd0, 1'b0}) begin
      bad++; $display("FAIL uw_rem_ovf got=%h/%b want=0/0", remainder_o, overflow_o);
    end
    start_div(1'b0, 32'd5, 32'd0, 32'd5);
    wait_done(lat, bc);
    total++; if (lat !== 2) begin bad++; $display("FAIL uovf_latency got=%0d want=2", lat); end
    total++; if ({overflow_o, div_zero_o} !== 2'b10) begin
      bad++; $display("FAIL uovf_flags got=%b want=10", {overflow_o, div_zero_o});
    end
    total++; if ({quotient_o, remainder_o} !== {32'hFFFF_FFFF, 32'd0}) begin
      bad++; $display("FAIL uovf_qr got=%h/%h want=ffffffff/0", quotient_o, remainder_o);
    end
  endtask

  task automatic test_signed;
    int lat, bc;
    start_div(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7);
    wait_done(lat, bc);
    total++; if (lat !== 35) begin bad++; $display("FAIL s1_latency got=%0d want=35", lat); end
    total++; if ({quotient_o, remainder_o} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE}) begin
      bad++; $display("FAIL s1_qr got=%h/%h want=fffffff2/fffffffe", quotient_o, remainder_o);
    end
    start_div(1'b1, 32'd0, 32'd100, 32'hFFFF_FFF9);
    wait_done(lat, bc);
    total++; if ({quotient_o, remainder_o} !== {32'hFFFF_FFF2, 32'd2}) begin
      bad++; $display("FAIL s2_qr got=%h/%h want=fffffff2/2", quotient_o, remainder_o);
    end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL s2_ovf got=%b want=0", overflow_o); end
  endtask

  task automatic test_signed_boundary;
    int lat, bc;
    start_div(1'b1, 32'd0, 32'h8000_0000, 32'd1);
    wait_done(lat, bc);
    total++; if (lat !== 35) begin bad++; $display("FAIL sb1_latency got=%0d want=35", lat); end
    total++; if ({overflow_o, quotient_o, remainder_o} !== {1'b1, 32'hFFFF_FFFF, 32'd0}) begin
      bad++; $display("FAIL sb1_ovf got=%b/%h/%h want=1/ffffffff/0", overflow_o, quotient_o, remainder_o);
    end
    start_div(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1);
    wait_done(lat, bc);
    total++; if ({overflow_o, quotient_o, remainder_o} !== {1'b0, 32'h8000_0000, 32'd0}) begin
      bad++; $display("FAIL sb2_min got=%b/%h/%h want=0/80000000/0", overflow_o, quotient_o, remainder_o);
    end
  endtask

  task automatic test_divzero;
    int lat, bc;
    start_div(1'b0, 32'd0, 32'h1234, 32'd0);
    wait_done(lat, bc);
    total++; if (lat !== 2) begin bad++; $display("FAIL dz_latency got=%0d want=2", lat); end
    total++; if ({div_zero_o, overflow_o} !== 2'b10) begin
      bad++; $display("FAIL dz_flags got=%b want=10", {div_zero_o, overflow_o});
    end
    total++; if ({quotient_o, remainder_o} !== {32'hFFFF_FFFF, 32'h1234}) begin
      bad++; $display("FAIL dz_qr got=%h/%h want=ffffffff/1234", quotient_o, remainder_o);
    end
    start_div(1'b0, 32'd0, 32'd100, 32'd7);
    @(negedge clk_i);
    start_i = 1'b0;
    total++; if (div_zero_o !== 1'b0) begin bad++; $display("FAIL dz_clear_on_start got=%b want=0", div_zero_o); end
    wait_done(lat, bc);
    total++; if ({div_zero_o, quotient_o} !== {1'b0, 32'd14}) begin
      bad++; $display("FAIL dz_next got=%b/%h want=0/e", div_zero_o, quotient_o);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    lat = 0;
    start_div(1'b0, 32'd0, 32'd100, 32'd7);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk_i);
      start_i = (c == 5);
      if (c == 5) begin
        dividend_lo_i = 32'd50;
        divisor_i     = 32'd5;
      end
      if (done_o) begin
        lat = c;
        break;
      end
    end
    start_i = 1'b0;
    total++; if (lat !== 35) begin bad++; $display("FAIL ign_latency got=%0d want=35", lat); end
    total++; if ({quotient_o, remainder_o} !== {32'd14, 32'd2}) begin
      bad++; $display("FAIL ign_qr got=%h/%h want=e/2", quotient_o, remainder_o);
    end
    @(negedge clk_i);
    total++; if ({done_o, busy_o} !== 2'b00) begin
      bad++; $display("FAIL ign_no_second got=%b want=00", {done_o, busy_o});
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    start_div(1'b0, 32'd0, 32'd200, 32'd7);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    total++; if ({busy_o, done_o, div_zero_o, overflow_o, quotient_o, remainder_o} !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%b%b%b%b/%h/%h want=0", busy_o, done_o, div_zero_o,
                      overflow_o, quotient_o, remainder_o);
    end
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o || busy_o) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    lat1 = 0;
    lat2 = 0;
    start_div(1'b0, 32'd0, 32'd100, 32'd7);
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk_i);
      if (c == 1) dividend_lo_i = 32'd200;
      if (lat1 != 0) start_i = 1'b0;
      if (done_o && lat1 == 0) begin
        lat1 = c;
        total++; if ({quotient_o, remainder_o} !== {32'd14, 32'd2}) begin
          bad++; $display("FAIL b2b_first got=%h/%h want=e/2", quotient_o, remainder_o);
        end
      end else if (done_o) begin
        lat2 = c;
        break;
      end
    end
    start_i = 1'b0;
    total++; if (lat1 !== 35) begin bad++; $display("FAIL b2b_lat1 got=%0d want=35", lat1); end
    total++; if (lat2 !== 70) begin bad++; $display("FAIL b2b_lat2 got=%0d want=70", lat2); end
    total++; if ({quotient_o, remainder_o} !== {32'd28, 32'd4}) begin
      bad++; $display("FAIL b2b_second got=%h/%h want=1c/4", quotient_o, remainder_o);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_unsigned_wide();
    test_signed();
    test_signed_boundary();
    test_divzero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
